// File: rtl/vjtag_dr_ctrl.sv
// Virtual JTAG user data register controller: captures rd_data, shifts it out
// LSB-first while shifting tdi in, commits the word on a full-length update.
// All state on rising tck; tdo is combinational; async active-high reset.
module vjtag_dr_ctrl #(
  parameter int DR_WIDTH = 16
) (
  input  logic                tck,
  input  logic                rst,
  input  logic                ir_in,
  input  logic                tdi,
  output logic                tdo,
  output logic                ir_out,
  input  logic                virtual_state_cdr,
  input  logic                virtual_state_sdr,
  input  logic                virtual_state_e1dr,
  input  logic                virtual_state_pdr,
  input  logic                virtual_state_e2dr,
  input  logic                virtual_state_udr,
  input  logic                virtual_state_cir,
  input  logic                virtual_state_uir,
  input  logic [DR_WIDTH-1:0] rd_data,
  output logic [DR_WIDTH-1:0] wr_data,
  output logic                wr_valid,
  output logic                shift_err,
  output logic                busy
);

  // Counter must reach DR_WIDTH+1 so over-long shifts stay distinguishable.
  localparam int CW = $clog2(DR_WIDTH + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(DR_WIDTH);
  localparam logic [CW-1:0] CNT_SAT  = CW'(DR_WIDTH + 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [DR_WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                byp_q, byp_d;
  logic [DR_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                wr_valid_q, wr_valid_d;
  logic                shift_err_q, shift_err_d;

  // Next-state logic: one virtual TAP event per cycle, cdr > sdr > udr > cir/uir > pause states.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    byp_d       = byp_q;
    wr_data_d   = wr_data_q;
    wr_valid_d  = 1'b0;
    shift_err_d = shift_err_q;

    if (virtual_state_cdr) begin
      if (ir_in) begin
        // Capture also restarts a transaction already in progress.
        state_d = ST_ACTIVE;
        sr_d    = rd_data;
        cnt_d   = '0;
      end else begin
        byp_d = 1'b0;
      end
    end else if (virtual_state_sdr) begin
      if (!ir_in) begin
        byp_d = tdi;
      end else if (state_q == ST_ACTIVE) begin
        sr_d = {tdi, sr_q[DR_WIDTH-1:1]};
        if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end else if (virtual_state_udr) begin
      if (state_q == ST_ACTIVE) begin
        state_d = ST_IDLE;
        if (cnt_q == CNT_FULL) begin
          wr_data_d  = sr_q;
          wr_valid_d = 1'b1;
        end else begin
          // udr outranks uir, so a coincident clear never masks this set.
          shift_err_d = 1'b1;
        end
      end
    end else if (virtual_state_cir || virtual_state_uir) begin
      state_d = ST_IDLE;
      if (virtual_state_uir) begin
        shift_err_d = 1'b0;
      end
    end else if (virtual_state_e1dr || virtual_state_pdr || virtual_state_e2dr) begin
      // Exit/pause states: shift register, count and state all hold.
      state_d = state_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge tck or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      byp_q       <= 1'b0;
      wr_data_q   <= '0;
      wr_valid_q  <= 1'b0;
      shift_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      byp_q       <= byp_d;
      wr_data_q   <= wr_data_d;
      wr_valid_q  <= wr_valid_d;
      shift_err_q <= shift_err_d;
    end
  end

  assign tdo       = ir_in ? sr_q[0] : byp_q;
  assign ir_out    = shift_err_q;
  assign wr_data   = wr_data_q;
  assign wr_valid  = wr_valid_q;
  assign shift_err = shift_err_q;
  assign busy      = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_vjtag_dr_ctrl.sv
// Bench for vjtag_dr_ctrl: directed scenarios plus randomized transactions.
// Commits are checked by a monitor against a queue of expected words.
// tdo, flags and busy are checked against a transaction-level model.
module tb_vjtag_dr_ctrl;
  localparam int W = 16;
  localparam logic [7:0] V_CDR = 8'h01, V_SDR = 8'h02, V_E1 = 8'h04, V_PDR = 8'h08;
  localparam logic [7:0] V_E2 = 8'h10, V_UDR = 8'h20, V_CIR = 8'h40, V_UIR = 8'h80;

  logic tck = 1'b0;
  logic rst, ir_in, tdi, tdo, ir_out;
  logic v_cdr, v_sdr, v_e1, v_pdr, v_e2, v_udr, v_cir, v_uir;
  logic [W-1:0] rd_data, wr_data;
  logic wr_valid, shift_err, busy;

  int errors = 0;
  int checks = 0;
  logic last_tdo;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] wr_m;
  logic err_m;
  logic prev_wv;
  logic [W-1:0] mon_w;

  vjtag_dr_ctrl #(.DR_WIDTH(W)) dut (
    .tck(tck), .rst(rst), .ir_in(ir_in), .tdi(tdi), .tdo(tdo), .ir_out(ir_out),
    .virtual_state_cdr(v_cdr), .virtual_state_sdr(v_sdr), .virtual_state_e1dr(v_e1),
    .virtual_state_pdr(v_pdr), .virtual_state_e2dr(v_e2), .virtual_state_udr(v_udr),
    .virtual_state_cir(v_cir), .virtual_state_uir(v_uir),
    .rd_data(rd_data), .wr_data(wr_data), .wr_valid(wr_valid),
    .shift_err(shift_err), .busy(busy)
  );

  always #5 tck = ~tck;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every wr_valid pulse must match the next expected commit.
  always @(negedge tck) begin
    if (rst) begin
      prev_wv = 1'b0;
    end else begin
      if (wr_valid) begin
        check("wr_valid_single_cycle", {31'd0, prev_wv}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_wr_valid", 32'd1, 32'd0);
        end else begin
          mon_w = exp_q.pop_front();
          check("commit_wr_data", {16'd0, wr_data}, {16'd0, mon_w});
        end
      end
      prev_wv = wr_valid;
    end
  end

  task automatic cyc(input logic [7:0] vs, input logic b);
    {v_uir, v_cir, v_udr, v_e2, v_pdr, v_e1, v_sdr, v_cdr} = vs;
    tdi = b;
    @(negedge tck);
    last_tdo = tdo;
    @(posedge tck);
    #1;
  endtask

  task automatic check_idle_state(input string nm);
    check({nm, "_busy"}, {31'd0, busy}, 32'd0);
    check({nm, "_shift_err"}, {31'd0, shift_err}, {31'd0, err_m});
    check({nm, "_ir_out"}, {31'd0, ir_out}, {31'd0, err_m});
    check({nm, "_wr_data"}, {16'd0, wr_data}, {16'd0, wr_m});
  endtask

  // One DATA transaction: capture (plus coincident extra events cx), n shifts,
  // optional pause before shift pz, optional bypass excursion before shift bx,
  // then end vector ev. tdo during shift k is rd[k], then the tdi bits shifted in.
  task automatic txn(input string nm, input logic [W-1:0] rd, input int n,
                     input logic [63:0] bits, input int pz, input int pl,
                     input int bx, input logic [7:0] cx, input logic [7:0] ev);
    logic expb, prev, b;
    ir_in = 1'b1;
    rd_data = rd;
    cyc(V_CDR | cx, 1'b0);
    check({nm, "_busy_after_cdr"}, {31'd0, busy}, 32'd1);
    for (int k = 0; k < n; k++) begin
      if (k == pz) begin
        cyc(V_E1, 1'b1);
        for (int p = 0; p < pl; p++) cyc(V_PDR, 1'($urandom));
        cyc(V_E2, 1'b1);
      end
      if (k == bx) begin
        ir_in = 1'b0;
        cyc(V_CDR, 1'b1);
        prev = 1'b0;
        for (int j = 0; j < 3; j++) begin
          b = 1'($urandom);
          cyc(V_SDR, b);
          check({nm, "_bypass_tdo"}, {31'd0, last_tdo}, {31'd0, prev});
          prev = b;
        end
        check({nm, "_busy_in_bypass"}, {31'd0, busy}, 32'd1);
        ir_in = 1'b1;
      end
      cyc(V_SDR, bits[k]);
      expb = (k < W) ? rd[k] : bits[k - W];
      check({nm, "_tdo"}, {31'd0, last_tdo}, {31'd0, expb});
    end
    if ((ev & V_UDR) != 8'h00) begin
      if (n == W) begin
        wr_m = bits[W-1:0];
        exp_q.push_back(wr_m);
      end else begin
        err_m = 1'b1;
      end
    end else if ((ev & V_UIR) != 8'h00) begin
      err_m = 1'b0;
    end
    cyc(ev, 1'b0);
    cyc(8'h00, 1'b0);
    check_idle_state(nm);
  endtask

  initial begin
    logic [3:0] pat;
    logic prev;
    rst = 1'b1; ir_in = 1'b1; tdi = 1'b0; rd_data = '0;
    {v_uir, v_cir, v_udr, v_e2, v_pdr, v_e1, v_sdr, v_cdr} = 8'h00;
    wr_m = '0; err_m = 1'b0; prev_wv = 1'b0; last_tdo = 1'b0;
    #2;
    check("reset_tdo", {31'd0, tdo}, 32'd0);
    check("reset_wr_valid", {31'd0, wr_valid}, 32'd0);
    check_idle_state("reset");
    @(posedge tck); #1;
    rst = 1'b0;

    // Full write/read.
    txn("full", 16'hA5C3, W, 64'h1234, -1, 0, -1, 8'h00, V_UDR);
    // Short and long shifts, each followed by an error clear.
    txn("short", 16'h0F0F, W - 1, 64'hFFFF, -1, 0, -1, 8'h00, V_UDR);
    cyc(V_UIR, 1'b0); err_m = 1'b0;
    check("short_uir_clear", {31'd0, shift_err}, 32'd0);
    txn("long", 16'h3C3C, W + 1, 64'h1ABCD, -1, 0, -1, 8'h00, V_UDR);
    cyc(V_UIR, 1'b0); err_m = 1'b0;
    check("long_uir_clear", {31'd0, ir_out}, 32'd0);
    // Pause in the middle.
    txn("pause", 16'h5555, W, 64'hBEEF, 8, 5, -1, 8'h00, V_UDR);
    // Abort with a pending error flag: flag and wr_data must survive.
    txn("short2", 16'h1111, 3, 64'h7, -1, 0, -1, 8'h00, V_UDR);
    txn("abort", 16'h2222, 10, 64'h3FF, -1, 0, -1, 8'h00, V_CIR);
    // Coincident udr and uir on a bad length: the set wins.
    txn("udr_uir", 16'h4444, W - 1, 64'h0, -1, 0, -1, 8'h00, V_UDR | V_UIR);

    // Bypass path: tdo lags tdi by one shift; no transaction starts.
    ir_in = 1'b0;
    cyc(V_CDR, 1'b0);
    pat = 4'b1101;
    prev = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc(V_SDR, pat[k]);
      check("bypass_tdo", {31'd0, last_tdo}, {31'd0, prev});
      check("bypass_busy", {31'd0, busy}, 32'd0);
      prev = pat[k];
    end
    cyc(8'h00, 1'b0);
    check_idle_state("bypass");

    // Reset mid-shift with byp, shift_err and wr_data all nonzero beforehand.
    ir_in = 1'b1;
    rd_data = 16'hFFFF;
    cyc(V_CDR, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cyc(V_SDR, 1'b1);
      check("rst_pre_tdo", {31'd0, last_tdo}, 32'd1);
    end
    rst = 1'b1;
    {v_uir, v_cir, v_udr, v_e2, v_pdr, v_e1, v_sdr, v_cdr} = 8'h00;
    #1;
    wr_m = '0; err_m = 1'b0;
    check("rst_mid_tdo_dr", {31'd0, tdo}, 32'd0);
    check("rst_mid_wr_valid", {31'd0, wr_valid}, 32'd0);
    check_idle_state("rst_mid");
    ir_in = 1'b0;
    #1;
    check("rst_mid_tdo_byp", {31'd0, tdo}, 32'd0);
    ir_in = 1'b1;
    @(posedge tck); #1;
    rst = 1'b0;
    txn("after_rst", 16'h9876, W, 64'hC0DE, -1, 0, -1, 8'h00, V_UDR);

    // Restart: a second capture mid-shift (with a coincident sdr) reloads and clears the count.
    rd_data = 16'h00FF;
    cyc(V_CDR, 1'b0);
    for (int k = 0; k < 5; k++) cyc(V_SDR, 1'b0);
    txn("restart", 16'hA0A0, W, 64'h5A5A, -1, 0, 4, V_SDR, V_UDR);

    // Randomized transactions.
    for (int t = 0; t < 40; t++) begin
      logic [W-1:0] rd;
      logic [63:0] bits;
      logic [7:0] cx, ev;
      int n, pz, pl, bx, r;
      rd = W'($urandom);
      bits = {$urandom, $urandom};
      r = $urandom_range(0, 5);
      n = (r == 0) ? W - 1 : (r == 1) ? W + 1 : (r == 5) ? $urandom_range(0, W + 4) : W;
      pz = ($urandom_range(0, 2) == 0) ? $urandom_range(0, W) : -1;
      pl = $urandom_range(0, 3);
      bx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, W) : -1;
      r = $urandom_range(0, 3);
      cx = (r == 0) ? V_SDR : (r == 1) ? (V_UDR | V_UIR) : 8'h00;
      r = $urandom_range(0, 9);
      ev = (r == 7) ? V_CIR : (r == 8) ? V_UIR : (r == 9) ? (V_UDR | V_UIR | V_CIR) : V_UDR;
      txn("rand", rd, n, bits, pz, pl, bx, cx, ev);
      if ($urandom_range(0, 3) == 0) begin
        cyc(V_UIR, 1'b0);
        err_m = 1'b0;
        check("rand_uir_clear", {31'd0, shift_err}, 32'd0);
      end
    end

    cyc(8'h00, 1'b0);
    check("pending_commits", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
